btb_predictor: RTL and testbench

- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Sits upstream of the fetch stage. It looks up the current fetch PC combinationally and drives btb_target_pc, btb_pc_valid and btb_pc_predictTaken into the PC update logic.
- Trained one write per cycle by the execute stage with each resolved branch/jump outcome.
- Supports whole-table invalidation for fence.i / self-modifying code.

---
 rtl/btb_predictor.sv | 102 ++++++++++
 tb/tb_btb_predictor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Optional same-cycle update-to-lookup forwarding is enabled by defining BTB_FWD_EN.
module btb_predictor #(
    parameter int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        btb_clear,
    output logic [31:0] btb_target_pc,
    output logic        btb_pc_valid,
    output logic        btb_pc_predictTaken
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic [1:0]       w_new_ctr;
    logic             w_write;
    logic             w_fwd;
    logic             w_unused_lsbs;

    assign w_idx  = pc[IDX_W+1:2];
    assign w_tag  = pc[31:IDX_W+2];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_uidx = update_pc[IDX_W+1:2];
    assign w_utag = update_pc[31:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    // Byte offset within the word never participates in index or tag.
    assign w_unused_lsbs = ^{pc[1:0], update_pc[1:0]};

    // Not-taken misses are never allocated.
    assign w_write = update_en && !btb_clear && (w_uhit || update_taken);

    always_comb begin
        w_new_ctr = 2'b10;
        if (w_uhit) begin
            if (update_taken) begin
                w_new_ctr = (r_ctr[w_uidx] == 2'b11) ? 2'b11 : r_ctr[w_uidx] + 2'b01;
            end else begin
                w_new_ctr = (r_ctr[w_uidx] == 2'b00) ? 2'b00 : r_ctr[w_uidx] - 2'b01;
            end
        end
    end

`ifdef BTB_FWD_EN
    assign w_fwd = w_write && (w_uidx == w_idx) && (w_utag == w_tag);
`else
    assign w_fwd = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (btb_clear) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_write) begin
            r_valid[w_uidx] <= 1'b1;
            r_tag[w_uidx]   <= w_utag;
            r_ctr[w_uidx]   <= w_new_ctr;
            if (update_taken) begin
                r_target[w_uidx] <= update_target;
            end
        end
    end

    always_comb begin
        btb_pc_valid        = w_hit;
        btb_pc_predictTaken = w_hit && r_ctr[w_idx][1];
        btb_target_pc       = w_hit ? r_target[w_idx] : 32'h0;
        if (w_fwd) begin
            btb_pc_valid        = 1'b1;
            btb_pc_predictTaken = w_new_ctr[1];
            btb_target_pc       = update_taken ? update_target : r_target[w_idx];
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: reset, training, hysteresis, aliasing, clear, reset, bypass.
module tb_btb_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        btb_clear;
    logic [31:0] btb_target_pc;
    logic        btb_pc_valid;
    logic        btb_pc_predictTaken;

    int n_total;
    int n_bad;

    btb_predictor #(.ENTRIES(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc                  (pc),
        .update_en           (update_en),
        .update_pc           (update_pc),
        .update_target       (update_target),
        .update_taken        (update_taken),
        .btb_clear           (btb_clear),
        .btb_target_pc       (btb_target_pc),
        .btb_pc_valid        (btb_pc_valid),
        .btb_pc_predictTaken (btb_pc_predictTaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Present a lookup address, let it settle, and compare all three outputs.
    task automatic look(input string tag, input logic [31:0] a, input logic v, input logic t,
                        input logic [31:0] tgt);
        pc = a;
        #1;
        check({tag, ".valid"}, {31'b0, btb_pc_valid}, {31'b0, v});
        check({tag, ".taken"}, {31'b0, btb_pc_predictTaken}, {31'b0, t});
        check({tag, ".target"}, btb_target_pc, tgt);
    endtask

    task automatic upd(input logic [31:0] a, input logic [31:0] tgt, input logic tk);
        update_en     = 1'b1;
        update_pc     = a;
        update_target = tgt;
        update_taken  = tk;
        @(posedge clk);
        #1;
        update_en = 1'b0;
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b1;
        pc            = 32'h0;
        update_en     = 1'b0;
        update_pc     = 32'h0;
        update_target = 32'h0;
        update_taken  = 1'b0;
        btb_clear     = 1'b0;

        // 1: every index misses out of reset
        #2;
        for (int i = 0; i < 16; i++) begin
            look("rst_idx", 32'h40 + 32'(i) * 4, 1'b0, 1'b0, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2: taken-miss allocates at ctr=10, then promote to 11
        upd(32'h40, 32'h100, 1'b1);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 32'h100, 1'b1);
        upd(32'h40, 32'h100, 1'b1);

        // 3: hysteresis down from 11, saturate at 00, then climb one step
        upd(32'h40, 32'h999, 1'b0);
        look("nt1", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 32'h999, 1'b0);
        look("nt2", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 32'h999, 1'b0);
        upd(32'h40, 32'h999, 1'b0);
        upd(32'h40, 32'h100, 1'b1);
        look("sat0_up1", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 32'h100, 1'b1);
        look("sat0_up2", 32'h40, 1'b1, 1'b1, 32'h100);

        // 4: alias eviction on taken miss; untaken misses never allocate
        upd(32'h440, 32'h300, 1'b1);
        look("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
        look("alias_new", 32'h440, 1'b1, 1'b1, 32'h300);
        look("alias_lsb", 32'h442, 1'b1, 1'b1, 32'h300);
        upd(32'h40, 32'h700, 1'b0);
        look("alias_ntkeep", 32'h440, 1'b1, 1'b1, 32'h300);
        upd(32'h80, 32'h500, 1'b0);
        look("nt_miss", 32'h80, 1'b0, 1'b0, 32'h0);

        // 5: clear beats a coincident allocate
        btb_clear = 1'b1;
        upd(32'hC0, 32'h600, 1'b1);
        btb_clear = 1'b0;
        look("clr_c0", 32'hC0, 1'b0, 1'b0, 32'h0);
        look("clr_440", 32'h440, 1'b0, 1'b0, 32'h0);

        // asynchronous reset drops a live hit without any clock edge
        upd(32'h40, 32'h100, 1'b1);
        look("pre_rst", 32'h40, 1'b1, 1'b1, 32'h100);
        rst = 1'b1;
        look("async_rst", 32'h40, 1'b0, 1'b0, 32'h0);
        // an update spanning an edge under reset is discarded
        upd(32'h80, 32'h500, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        look("rst_discard", 32'h80, 1'b0, 1'b0, 32'h0);

        // 6: same-cycle update and lookup of one entry
        upd(32'h40, 32'h100, 1'b1);
        pc            = 32'h40;
        update_en     = 1'b1;
        update_pc     = 32'h40;
        update_target = 32'h200;
        update_taken  = 1'b1;
`ifdef BTB_FWD_EN
        look("same_cyc", 32'h40, 1'b1, 1'b1, 32'h200);
`else
        look("same_cyc", 32'h40, 1'b1, 1'b1, 32'h100);
`endif
        @(posedge clk);
        #1;
        update_en = 1'b0;
        look("next_cyc", 32'h40, 1'b1, 1'b1, 32'h200);

        // a not-taken miss is never bypassed
        update_en     = 1'b1;
        update_pc     = 32'h80;
        update_target = 32'h500;
        update_taken  = 1'b0;
        look("fwd_ntmiss", 32'h80, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        update_en = 1'b0;
        look("ntmiss_after", 32'h80, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
